ps2_morse_top: RTL and testbench
================================

// Module: ps2_morse_top
// PURPOSE
//  Top-level PS/2-keyboard-to-Morse transmitter. Receives PS/2 scan codes and buffers supported
//  characters in a FIFO. On Enter it keys them out as Morse on dit/dah/morse outputs, plus an
//  audible square-wave tone. Internally: PS/2 receiver -> scan-code decoder/FIFO ->
//  Morse sequencer -> tone generator. Device-to-host only; the block never drives PS/2 lines.
// PARAMETERS
//  UNIT_CYCLES   2_500_000  clk cycles per Morse unit (50 ms @ 50 MHz); benches override small
//  DIT_HALF      25_000     tone half-period in clk cycles while dit active (1 kHz)
//  DAH_HALF      31_250     tone half-period in clk cycles while dah active (800 Hz)
//  FIFO_DEPTH    32         character buffer entries (power of two)
//  PS2_TIMEOUT   50_000     clk cycles without PS/2 falling edge that abort a partial frame
// PORTS
//  clk             in   1  system clock, 50 MHz
//  rst             in   1  asynchronous reset, active-high
//  ps2_clk         in   1  PS/2 clock from keyboard (asynchronous)
//  ps2_data        in   1  PS/2 data from keyboard (asynchronous)
//  dit_out         out  1  high for the duration of a dit element
//  dah_out         out  1  high for the duration of a dah element
//  morse_code_out  out  1  dit_out | dah_out (keying line)
//  tone_out        out  1  square wave while keying, else 0
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; receiver, decoder and sequencer idle; prefix flags clear.
//  PS/2 RX: ps2_clk/ps2_data 2-FF synchronised. Sample data on each synchronised ps2_clk falling edge.
//   Frame = start 0, 8 data LSB-first, odd parity, stop 1 (11 edges).
//   Valid frame: 1-cycle byte strobe within 4 clk of the 11th edge.
//   Bad start/parity/stop: frame dropped silently.
//   No edge for PS2_TIMEOUT cycles mid-frame: bit counter cleared.
//  Decoder (per strobed byte):
//   0xF0 = break prefix; 0xE0 = extended prefix. The following byte is discarded and the flag cleared.
//   Set-2 make codes A-Z, 0-9 and 0x29 Space: pushed to FIFO as 6-bit symbol.
//   0x5A Enter: sets play request. Every other code (e.g. 0x0C F4) is ignored.
//   FIFO full: new symbols dropped; existing contents unchanged.
//  Sequencer FSM: IDLE -> LOAD -> MARK -> SPACE -> (MARK | CHAR_GAP) -> LOAD ...; WORD_GAP.
//   IDLE: leave only when play request set and FIFO non-empty; clear request.
//   LOAD: pop one symbol and look up {length 1-5, pattern MSB-first, 1 = dah}.
//   Space symbol -> WORD_GAP.
//   MARK: dit = 1 unit with dit_out=1; dah = 3 units with dah_out=1.
//   SPACE: 1 unit all low; then next element, or CHAR_GAP after last element.
//   CHAR_GAP: 2 further units (3 total inter-character). WORD_GAP: 7 units low.
//   After a gap: LOAD if FIFO non-empty, else IDLE.
//   Symbols pushed during playback are sent in the same run.
//   Enter during playback is latched and only takes effect when the sequencer is IDLE.
//  Tone: free-running half-period counter, restarted on every dit/dah rising edge.
//   Toggles at DIT_HALF while dit_out=1 and at DAH_HALF while dah_out=1.
//   Forced 0 (counter cleared) when neither is high.
//  Simultaneous push and pop: both honoured; count unchanged.
//  Async reset mid-frame or mid-playback aborts immediately to reset state.
// TESTING
//  1 Frame 0x1C (A), parity 0, stop 1 -> one strobe with byte 0x1C; FIFO count 1; no keying yet.
//  2 A, Space, B, Enter -> dit U, low U, dah 3U, low 3U, low 7U, then B = dah 3U + 3 dits, -> IDLE.
//  3 F0 then 21 (C release), then F4 (0x0C) -> FIFO unchanged; next A still encoded normally.
//  4 A frame with parity bit 1 -> no strobe, FIFO unchanged; next valid frame still received.
//  5 During A dah, tone_out toggles every DAH_HALF; during dit every DIT_HALF; 0 in gaps.
//  6 Fill 33 symbols then Enter -> exactly 32 characters keyed; rst mid-dah -> outputs 0 at once.

Source files
------------

// File: rtl/ps2_morse_top.sv
// PS/2 keyboard to Morse transmitter: PS/2 receiver, scan-code decoder with symbol FIFO,
// Morse element sequencer and square-wave tone generator.
module ps2_morse_top #(
    parameter int UNIT_CYCLES = 2_500_000,
    parameter int DIT_HALF    = 25_000,
    parameter int DAH_HALF    = 31_250,
    parameter int FIFO_DEPTH  = 32,
    parameter int PS2_TIMEOUT = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic dit_out,
    output logic dah_out,
    output logic morse_code_out,
    output logic tone_out
);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int TMR_W    = $clog2(7 * UNIT_CYCLES);
    localparam int TO_W     = $clog2(PS2_TIMEOUT) + 1;
    localparam int HALF_MAX = (DAH_HALF > DIT_HALF) ? DAH_HALF : DIT_HALF;
    localparam int TONE_W   = $clog2(HALF_MAX) + 1;

    localparam logic [TMR_W-1:0]  TMR_ZERO = TMR_W'(0);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0]  DIT_LD   = TMR_W'(UNIT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  DAH_LD   = TMR_W'(3 * UNIT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  CHAR_LD  = TMR_W'(2 * UNIT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  WORD_LD  = TMR_W'(7 * UNIT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LIM   = TO_W'(PS2_TIMEOUT - 1);
    localparam logic [TONE_W-1:0] DIT_TOP  = TONE_W'(DIT_HALF - 1);
    localparam logic [TONE_W-1:0] DAH_TOP  = TONE_W'(DAH_HALF - 1);
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [5:0]        SYM_SPACE = 6'd36;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_MARK     = 3'd2,
        S_SPACE    = 3'd3,
        S_CHAR_GAP = 3'd4,
        S_WORD_GAP = 3'd5
    } seq_state_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Returns {valid, symbol}: A-Z = 0..25, 0-9 = 26..35, Space = 36.
    function automatic logic [6:0] scan_to_sym(input logic [7:0] code);
        logic [6:0] r;
        case (code)
            8'h1C: r = 7'd64;  8'h32: r = 7'd65;  8'h21: r = 7'd66;  8'h23: r = 7'd67;
            8'h24: r = 7'd68;  8'h2B: r = 7'd69;  8'h34: r = 7'd70;  8'h33: r = 7'd71;
            8'h43: r = 7'd72;  8'h3B: r = 7'd73;  8'h42: r = 7'd74;  8'h4B: r = 7'd75;
            8'h3A: r = 7'd76;  8'h31: r = 7'd77;  8'h44: r = 7'd78;  8'h4D: r = 7'd79;
            8'h15: r = 7'd80;  8'h2D: r = 7'd81;  8'h1B: r = 7'd82;  8'h2C: r = 7'd83;
            8'h3C: r = 7'd84;  8'h2A: r = 7'd85;  8'h1D: r = 7'd86;  8'h22: r = 7'd87;
            8'h35: r = 7'd88;  8'h1A: r = 7'd89;
            8'h45: r = 7'd90;  8'h16: r = 7'd91;  8'h1E: r = 7'd92;  8'h26: r = 7'd93;
            8'h25: r = 7'd94;  8'h2E: r = 7'd95;  8'h36: r = 7'd96;  8'h3D: r = 7'd97;
            8'h3E: r = 7'd98;  8'h46: r = 7'd99;
            8'h29: r = 7'd100;
            default: r = 7'd0;
        endcase
        return r;
    endfunction

    // Returns {length, pattern}; pattern is left-aligned so bit 4 is the first element, 1 = dah.
    function automatic logic [7:0] sym_to_morse(input logic [5:0] sym);
        logic [7:0] r;
        case (sym)
            6'd0:  r = {3'd2, 5'b01000};  6'd1:  r = {3'd4, 5'b10000};
            6'd2:  r = {3'd4, 5'b10100};  6'd3:  r = {3'd3, 5'b10000};
            6'd4:  r = {3'd1, 5'b00000};  6'd5:  r = {3'd4, 5'b00100};
            6'd6:  r = {3'd3, 5'b11000};  6'd7:  r = {3'd4, 5'b00000};
            6'd8:  r = {3'd2, 5'b00000};  6'd9:  r = {3'd4, 5'b01110};
            6'd10: r = {3'd3, 5'b10100};  6'd11: r = {3'd4, 5'b01000};
            6'd12: r = {3'd2, 5'b11000};  6'd13: r = {3'd2, 5'b10000};
            6'd14: r = {3'd3, 5'b11100};  6'd15: r = {3'd4, 5'b01100};
            6'd16: r = {3'd4, 5'b11010};  6'd17: r = {3'd3, 5'b01000};
            6'd18: r = {3'd3, 5'b00000};  6'd19: r = {3'd1, 5'b10000};
            6'd20: r = {3'd3, 5'b00100};  6'd21: r = {3'd4, 5'b00010};
            6'd22: r = {3'd3, 5'b01100};  6'd23: r = {3'd4, 5'b10010};
            6'd24: r = {3'd4, 5'b10110};  6'd25: r = {3'd4, 5'b11000};
            6'd26: r = {3'd5, 5'b11111};  6'd27: r = {3'd5, 5'b01111};
            6'd28: r = {3'd5, 5'b00111};  6'd29: r = {3'd5, 5'b00011};
            6'd30: r = {3'd5, 5'b00001};  6'd31: r = {3'd5, 5'b00000};
            6'd32: r = {3'd5, 5'b10000};  6'd33: r = {3'd5, 5'b11000};
            6'd34: r = {3'd5, 5'b11100};  6'd35: r = {3'd5, 5'b11110};
            default: r = {3'd1, 5'b00000};
        endcase
        return r;
    endfunction

    logic [1:0]        clk_sync_r, dat_sync_r;
    logic              clk_prev_r;
    logic [10:0]       shift_r;
    logic [3:0]        bit_cnt_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              byte_stb_r;
    logic [7:0]        byte_r;
    logic              fall_s;
    logic [10:0]       frame_s;

    logic              break_r, ext_r, play_req_r;
    logic [6:0]        sym_lu_s;
    logic              push_s, enter_s, pop_s, play_clr_s;

    logic [5:0]        fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]    fifo_cnt_r;
    logic              fifo_full_s, fifo_empty_s;
    logic [5:0]        fifo_rd_s;

    seq_state_t        state_r, state_s;
    logic [TMR_W-1:0]  tmr_r, tmr_s;
    logic [2:0]        idx_r, idx_s, len_r, len_s;
    logic [4:0]        pat_r, pat_s;
    logic [7:0]        morse_lu_s;
    logic              cur_dah_s, dit_s, dah_s;
    logic              dit_r, dah_r, morse_r, dit_d_r, dah_d_r;
    logic [TONE_W-1:0] tone_cnt_r;
    logic [TONE_W-1:0] tone_top_s;
    logic              tone_r;

    // The 11th bit is the one arriving with the current falling edge, so validate the merged view.
    assign fall_s       = clk_prev_r & ~clk_sync_r[1];
    assign frame_s      = {dat_sync_r[1], shift_r[10:1]};
    assign fifo_full_s  = (fifo_cnt_r == CNT_FULL);
    assign fifo_empty_s = (fifo_cnt_r == {(PTR_W + 1){1'b0}});
    assign fifo_rd_s    = fifo_mem_r[rd_ptr_r];

    // PS/2 synchronisers, frame shifter, timeout and byte strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_r <= 2'b11;
            dat_sync_r <= 2'b11;
            clk_prev_r <= 1'b1;
            shift_r    <= 11'd0;
            bit_cnt_r  <= 4'd0;
            to_cnt_r   <= {TO_W{1'b0}};
            byte_stb_r <= 1'b0;
            byte_r     <= 8'd0;
        end else begin
            clk_sync_r <= {clk_sync_r[0], ps2_clk};
            dat_sync_r <= {dat_sync_r[0], ps2_data};
            clk_prev_r <= clk_sync_r[1];
            byte_stb_r <= 1'b0;
            if (fall_s) begin
                to_cnt_r <= {TO_W{1'b0}};
                shift_r  <= frame_s;
                if (bit_cnt_r == 4'd10) begin
                    bit_cnt_r <= 4'd0;
                    if (!frame_s[0] && frame_s[10] && odd_parity_ok(frame_s[8:1], frame_s[9])) begin
                        byte_stb_r <= 1'b1;
                        byte_r     <= frame_s[8:1];
                    end
                end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
            end else if (bit_cnt_r != 4'd0) begin
                if (to_cnt_r == TO_LIM) begin
                    bit_cnt_r <= 4'd0;
                    to_cnt_r  <= {TO_W{1'b0}};
                end else begin
                    to_cnt_r <= to_cnt_r + TO_W'(1);
                end
            end else begin
                to_cnt_r <= {TO_W{1'b0}};
            end
        end
    end

    // Decode a strobed byte into a FIFO push or a play request; bytes after a prefix are swallowed.
    always_comb begin
        sym_lu_s = scan_to_sym(byte_r);
        push_s   = 1'b0;
        enter_s  = 1'b0;
        if (byte_stb_r && !break_r && !ext_r) begin
            push_s  = sym_lu_s[6] & ~fifo_full_s;
            enter_s = (byte_r == 8'h5A);
        end else begin
            push_s  = 1'b0;
            enter_s = 1'b0;
        end
    end

    // Prefix flags and the latched play request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            break_r    <= 1'b0;
            ext_r      <= 1'b0;
            play_req_r <= 1'b0;
        end else begin
            if (byte_stb_r) begin
                if (break_r || ext_r) begin
                    break_r <= 1'b0;
                    ext_r   <= 1'b0;
                end else if (byte_r == 8'hF0) begin
                    break_r <= 1'b1;
                end else if (byte_r == 8'hE0) begin
                    ext_r <= 1'b1;
                end
            end
            if (enter_s) begin
                play_req_r <= 1'b1;
            end else if (play_clr_s) begin
                play_req_r <= 1'b0;
            end
        end
    end

    // Symbol storage; contents are only meaningful below fifo_cnt_r, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= sym_lu_s[5:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - (PTR_W + 1)'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Sequencer next state; each timed state counts tmr down to zero.
    always_comb begin
        state_s    = state_r;
        tmr_s      = tmr_r;
        idx_s      = idx_r;
        len_s      = len_r;
        pat_s      = pat_r;
        pop_s      = 1'b0;
        play_clr_s = 1'b0;
        morse_lu_s = sym_to_morse(fifo_rd_s);
        case (state_r)
            S_IDLE: begin
                if (play_req_r && !fifo_empty_s) begin
                    state_s    = S_LOAD;
                    play_clr_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                pop_s = 1'b1;
                idx_s = 3'd0;
                if (fifo_rd_s == SYM_SPACE) begin
                    state_s = S_WORD_GAP;
                    tmr_s   = WORD_LD;
                end else begin
                    state_s = S_MARK;
                    len_s   = morse_lu_s[7:5];
                    pat_s   = morse_lu_s[4:0];
                    tmr_s   = morse_lu_s[4] ? DAH_LD : DIT_LD;
                end
            end
            S_MARK: begin
                if (tmr_r == TMR_ZERO) begin
                    state_s = S_SPACE;
                    tmr_s   = DIT_LD;
                end else begin
                    tmr_s = tmr_r - TMR_ONE;
                end
            end
            S_SPACE: begin
                if (tmr_r != TMR_ZERO) begin
                    tmr_s = tmr_r - TMR_ONE;
                end else if (idx_r == len_r - 3'd1) begin
                    state_s = S_CHAR_GAP;
                    tmr_s   = CHAR_LD;
                end else begin
                    state_s = S_MARK;
                    idx_s   = idx_r + 3'd1;
                    tmr_s   = pat_r[3'd3 - idx_r] ? DAH_LD : DIT_LD;
                end
            end
            S_CHAR_GAP, S_WORD_GAP: begin
                if (tmr_r != TMR_ZERO) begin
                    tmr_s = tmr_r - TMR_ONE;
                end else if (fifo_empty_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_LOAD;
                end
            end
            default: begin
                state_s = S_IDLE;
                tmr_s   = TMR_ZERO;
            end
        endcase
        cur_dah_s = pat_s[3'd4 - idx_s];
        dit_s     = (state_s == S_MARK) & ~cur_dah_s;
        dah_s     = (state_s == S_MARK) & cur_dah_s;
    end

    // Sequencer registers and keying outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            tmr_r   <= TMR_ZERO;
            idx_r   <= 3'd0;
            len_r   <= 3'd0;
            pat_r   <= 5'd0;
            dit_r   <= 1'b0;
            dah_r   <= 1'b0;
            morse_r <= 1'b0;
        end else begin
            state_r <= state_s;
            tmr_r   <= tmr_s;
            idx_r   <= idx_s;
            len_r   <= len_s;
            pat_r   <= pat_s;
            dit_r   <= dit_s;
            dah_r   <= dah_s;
            morse_r <= dit_s | dah_s;
        end
    end

    assign tone_top_s = dah_r ? DAH_TOP : DIT_TOP;

    // Tone generator: phase restarts on each element so every mark begins identically.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dit_d_r    <= 1'b0;
            dah_d_r    <= 1'b0;
            tone_cnt_r <= {TONE_W{1'b0}};
            tone_r     <= 1'b0;
        end else begin
            dit_d_r <= dit_r;
            dah_d_r <= dah_r;
            if (!(dit_r || dah_r)) begin
                tone_cnt_r <= {TONE_W{1'b0}};
                tone_r     <= 1'b0;
            end else if ((dit_r && !dit_d_r) || (dah_r && !dah_d_r)) begin
                tone_cnt_r <= {TONE_W{1'b0}};
                tone_r     <= 1'b0;
            end else if (tone_cnt_r == tone_top_s) begin
                tone_cnt_r <= {TONE_W{1'b0}};
                tone_r     <= ~tone_r;
            end else begin
                tone_cnt_r <= tone_cnt_r + TONE_W'(1);
            end
        end
    end

    assign dit_out        = dit_r;
    assign dah_out        = dah_r;
    assign morse_code_out = morse_r;
    assign tone_out       = tone_r;
endmodule

// File: tb/tb_ps2_morse_top.sv
// Directed bench for ps2_morse_top: PS/2 frames in, keyed element timing and tone observed.
module tb_ps2_morse_top;
    localparam int U  = 40;
    localparam int DH = 4;
    localparam int AH = 5;
    localparam int TO = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic dit_out, dah_out, morse_code_out, tone_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int stb_cnt = 0;
    logic [7:0] last_byte = 8'd0;

    int q_dah[$];
    int q_hi[$];
    int q_lo[$];
    bit m_prev = 1'b0;
    bit t_prev = 1'b0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    int cur_dah = 0;
    int tone_last = -1;
    int dit_min = 1000, dit_max = 0, dah_min = 1000, dah_max = 0;
    int gap_tone_err = 0;
    int excl_err = 0;

    ps2_morse_top #(
        .UNIT_CYCLES(U), .DIT_HALF(DH), .DAH_HALF(AH), .FIFO_DEPTH(32), .PS2_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .dit_out(dit_out), .dah_out(dah_out), .morse_code_out(morse_code_out), .tone_out(tone_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dut.byte_stb_r) begin
            stb_cnt++;
            last_byte = dut.byte_r;
        end
    end

    // Element recorder and tone-period tracker.
    always @(negedge clk) begin
        if (rst) begin
            m_prev = 1'b0;
            t_prev = 1'b0;
        end else begin
            if ((morse_code_out !== (dit_out | dah_out)) || (dit_out && dah_out)) excl_err++;
            if (morse_code_out && !m_prev) begin
                rise_cyc  = cyc;
                cur_dah   = dah_out ? 1 : 0;
                tone_last = -1;
            end
            if (!morse_code_out && m_prev) begin
                q_dah.push_back(cur_dah);
                q_hi.push_back(cyc - rise_cyc);
                q_lo.push_back(rise_cyc - fall_cyc);
                fall_cyc = cyc;
            end
            if ((tone_out != t_prev) && morse_code_out && m_prev) begin
                if (tone_last >= 0) begin
                    if (cur_dah == 1) begin
                        if (cyc - tone_last < dah_min) dah_min = cyc - tone_last;
                        if (cyc - tone_last > dah_max) dah_max = cyc - tone_last;
                    end else begin
                        if (cyc - tone_last < dit_min) dit_min = cyc - tone_last;
                        if (cyc - tone_last > dit_max) dit_max = cyc - tone_last;
                    end
                end
                tone_last = cyc;
            end
            if (tone_out && !morse_code_out && !m_prev) gap_tone_err++;
            m_prev = morse_code_out;
            t_prev = tone_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit bad_par);
        logic [10:0] bits;
        bits = {1'b1, (bad_par ? ^data : ~^data), data, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic clear_rec();
        q_dah.delete();
        q_hi.delete();
        q_lo.delete();
        dit_min = 1000; dit_max = 0; dah_min = 1000; dah_max = 0;
    endtask

    task automatic wait_elems(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (q_hi.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk(tag, 32'(q_hi.size()), 32'(n));
    endtask

    // Low gaps include the one-cycle symbol fetch, so allow up to two extra cycles.
    function automatic int gap_norm(input int v, input int nominal);
        return (v >= nominal && v <= nominal + 2) ? nominal : v;
    endfunction

    initial begin
        int s0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dit", 32'(dit_out), 32'd0);
        chk("rst_dah", 32'(dah_out), 32'd0);
        chk("rst_morse", 32'(morse_code_out), 32'd0);
        chk("rst_tone", 32'(tone_out), 32'd0);
        chk("rst_fifo", 32'(dut.fifo_cnt_r), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single A frame
        clear_rec();
        send_frame(8'h1C, 1'b0);
        chk("t1_strobes", 32'(stb_cnt), 32'd1);
        chk("t1_byte", 32'(last_byte), 32'h1C);
        chk("t1_fifo", 32'(dut.fifo_cnt_r), 32'd1);
        repeat (50) @(negedge clk);
        chk("t1_no_keying", 32'(q_hi.size()), 32'd0);

        // 2: A, Space, B, Enter
        send_frame(8'h29, 1'b0);
        send_frame(8'h32, 1'b0);
        send_frame(8'h5A, 1'b0);
        wait_elems(6, 3000, "t2_elems");
        if (q_hi.size() >= 6) begin
            chk("t2_a0_kind", 32'(q_dah[0]), 32'd0);
            chk("t2_a0_len", 32'(q_hi[0]), 32'(U));
            chk("t2_a1_kind", 32'(q_dah[1]), 32'd1);
            chk("t2_a1_len", 32'(q_hi[1]), 32'(3 * U));
            chk("t2_a1_gap", 32'(q_lo[1]), 32'(U));
            chk("t2_word_gap", 32'(gap_norm(q_lo[2], 10 * U)), 32'(10 * U));
            chk("t2_b0_kind", 32'(q_dah[2]), 32'd1);
            chk("t2_b0_len", 32'(q_hi[2]), 32'(3 * U));
            for (int i = 3; i < 6; i++) begin
                chk("t2_b_dit_kind", 32'(q_dah[i]), 32'd0);
                chk("t2_b_dit_len", 32'(q_hi[i]), 32'(U));
                chk("t2_b_dit_gap", 32'(q_lo[i]), 32'(U));
            end
        end
        repeat (4 * U) @(negedge clk);
        chk("t2_idle", 32'(dut.state_r), 32'd0);
        chk("t2_fifo_empty", 32'(dut.fifo_cnt_r), 32'd0);
        chk("t2_no_extra", 32'(q_hi.size()), 32'd6);

        // 3: break and ignored codes, then A
        clear_rec();
        s0 = stb_cnt;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h21, 1'b0);
        send_frame(8'h0C, 1'b0);
        chk("t3_strobes", 32'(stb_cnt - s0), 32'd3);
        chk("t3_fifo", 32'(dut.fifo_cnt_r), 32'd0);
        send_frame(8'h1C, 1'b0);
        chk("t3_fifo_a", 32'(dut.fifo_cnt_r), 32'd1);
        send_frame(8'h5A, 1'b0);
        wait_elems(2, 1000, "t3_elems");
        if (q_hi.size() >= 2) begin
            chk("t3_first_dit", 32'(q_dah[0]), 32'd0);
            chk("t3_second_dah", 32'(q_dah[1]), 32'd1);
        end
        repeat (4 * U) @(negedge clk);

        // 4: bad parity, truncated frame timeout, then a good frame
        clear_rec();
        s0 = stb_cnt;
        send_frame(8'h1C, 1'b1);
        chk("t4_badpar_strobe", 32'(stb_cnt - s0), 32'd0);
        chk("t4_badpar_fifo", 32'(dut.fifo_cnt_r), 32'd0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        repeat (TO + 100) @(negedge clk);
        send_frame(8'h1C, 1'b0);
        chk("t4_recover_strobe", 32'(stb_cnt - s0), 32'd1);
        chk("t4_recover_byte", 32'(last_byte), 32'h1C);
        chk("t4_recover_fifo", 32'(dut.fifo_cnt_r), 32'd1);

        // 5: play the buffered A and watch the tone
        clear_rec();
        send_frame(8'h5A, 1'b0);
        wait_elems(2, 1000, "t5_elems");
        chk("t5_dit_half_min", 32'(dit_min), 32'(DH));
        chk("t5_dit_half_max", 32'(dit_max), 32'(DH));
        chk("t5_dah_half_min", 32'(dah_min), 32'(AH));
        chk("t5_dah_half_max", 32'(dah_max), 32'(AH));
        repeat (4 * U) @(negedge clk);

        // 6: overfill with 33 E then Enter
        clear_rec();
        for (int i = 0; i < 33; i++) send_frame(8'h24, 1'b0);
        chk("t6_fifo_full", 32'(dut.fifo_cnt_r), 32'd32);
        send_frame(8'h5A, 1'b0);
        wait_elems(32, 8000, "t6_elems");
        repeat (6 * U) @(negedge clk);
        chk("t6_exact_32", 32'(q_hi.size()), 32'd32);
        chk("t6_fifo_empty", 32'(dut.fifo_cnt_r), 32'd0);
        s0 = 0;
        foreach (q_dah[i]) s0 += q_dah[i];
        chk("t6_all_dits", 32'(s0), 32'd0);

        // 6b: reset in the middle of a dah
        send_frame(8'h2C, 1'b0);
        send_frame(8'h24, 1'b0);
        send_frame(8'h5A, 1'b0);
        s0 = 0;
        while (!dah_out && s0 < 300) begin
            @(negedge clk);
            s0++;
        end
        chk("t6_dah_seen", 32'(dah_out), 32'd1);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_dah", 32'(dah_out), 32'd0);
        chk("t6_rst_morse", 32'(morse_code_out), 32'd0);
        chk("t6_rst_tone", 32'(tone_out), 32'd0);
        chk("t6_rst_fifo", 32'(dut.fifo_cnt_r), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * U) @(negedge clk);
        chk("t6_quiet_after_rst", 32'(morse_code_out), 32'd0);

        chk("gap_tone_clean", 32'(gap_tone_err), 32'd0);
        chk("keying_consistent", 32'(excl_err), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
